// File: rtl/img_stream_src.sv
// img_stream_src: frame-aware pixel streamer for the VGA write port.
// It walks an IMG_W x IMG_H raster and either reads each pixel from a
// synchronous image memory or generates it (colour bars, solid fill,
// checkerboard). Pixels leave through a valid/ready port together with
// their raster position and frame markers.
//
// Handshake: a pixel transfers on a rising clk edge where pix_valid and
// pix_ready are both 1. While pix_valid=1 and pix_ready=0, every pixel
// output holds its value, and pix_valid stays 1 until the transfer.
//
// Pipe: stage 1 is the raster counter, which drives mem_addr. A pixel
// issues when the output register is empty or is being drained. Stage 2
// is the output register. For memory pixels the data arrives one cycle
// after mem_rd, so pix_data takes mem_rdata directly in the first cycle
// the pixel is presented. On a stall that word is captured into a skid
// entry, because the memory output is not held once mem_rd drops.
module img_stream_src #(
  parameter  int IMG_W   = 256,
  parameter  int IMG_H   = 256,
  parameter  int PIX_W   = 12,
  parameter  int NUM_IMG = 2,
  localparam int XW      = $clog2(IMG_W),
  localparam int YW      = $clog2(IMG_H),
  localparam int IW      = $clog2(NUM_IMG),
  localparam int AW      = IW + YW + XW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [1:0]       mode,
  input  logic [IW-1:0]    img_sel,
  input  logic [PIX_W-1:0] fill_color,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rd,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic [XW-1:0]    pix_x,
  output logic [YW-1:0]    pix_y,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             busy,
  output logic             frame_done
);

  localparam int F = PIX_W / 3;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state_q, state_d;

  // Frame parameters latched at frame start.
  logic [1:0]       mode_q;
  logic [IW-1:0]    img_q;
  logic [PIX_W-1:0] fill_q;

  // Stage 1: raster counter. s1_done is set once the last pixel of the
  // frame has issued and the counter has wrapped back to (0,0).
  logic [XW-1:0]    cx;
  logic [YW-1:0]    cy;
  logic             s1_done;

  // Stage 2: output register and the skid entry for memory data.
  logic             o_valid, o_sof, o_eol, o_eof, o_mem;
  logic [XW-1:0]    o_x;
  logic [YW-1:0]    o_y;
  logic [PIX_W-1:0] o_gen;
  logic             hold_valid;
  logic [PIX_W-1:0] hold_data;

  // Combinational control.
  logic             hs, eof_hs, issue, use_new, last_pix;
  logic [1:0]       eff_mode;
  logic [IW-1:0]    eff_img;
  logic [PIX_W-1:0] eff_fill;
  logic [2:0]       bar_rgb;
  logic [PIX_W-1:0] gen_pix;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, issue decision and memory read strobe.
  always_comb begin
    state_d  = state_q;
    hs       = o_valid && pix_ready;
    eof_hs   = hs && o_eof;
    // While the counter waits at (0,0) after the last pixel, the next
    // frame's parameters are the live inputs. They are latched on the
    // issue that begins the back-to-back frame.
    use_new  = (state_q == STREAM) && s1_done;
    eff_mode = use_new ? mode       : mode_q;
    eff_img  = use_new ? img_sel    : img_q;
    eff_fill = use_new ? fill_color : fill_q;
    last_pix = (cx == X_MAX) && (cy == Y_MAX);
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = STREAM;
      end
      STREAM: begin
        issue = !start && (!o_valid || pix_ready) && (!s1_done || cont);
        if (!start && eof_hs && !cont) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_rd = issue && (eff_mode == 2'd0);
  end

  // Synthetic pixel for the position currently at stage 1.
  always_comb begin
    bar_rgb = 3'b000;
    gen_pix = '0;
    case (eff_mode)
      2'd1: begin
        case (cx[XW-1:XW-3])
          3'd0:    bar_rgb = 3'b111; // white
          3'd1:    bar_rgb = 3'b110; // yellow
          3'd2:    bar_rgb = 3'b011; // cyan
          3'd3:    bar_rgb = 3'b010; // green
          3'd4:    bar_rgb = 3'b101; // magenta
          3'd5:    bar_rgb = 3'b100; // red
          3'd6:    bar_rgb = 3'b001; // blue
          default: bar_rgb = 3'b000; // black
        endcase
        gen_pix = {{F{bar_rgb[2]}}, {F{bar_rgb[1]}}, {F{bar_rgb[0]}}};
      end
      2'd2:    gen_pix = eff_fill;
      2'd3:    gen_pix = {PIX_W{cx[3] ^ cy[3]}};
      default: gen_pix = '0;
    endcase
  end

  // Parameter latch, raster counter and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= '0;
      img_q      <= '0;
      fill_q     <= '0;
      cx         <= '0;
      cy         <= '0;
      s1_done    <= 1'b0;
      o_valid    <= 1'b0;
      o_sof      <= 1'b0;
      o_eol      <= 1'b0;
      o_eof      <= 1'b0;
      o_mem      <= 1'b0;
      o_x        <= '0;
      o_y        <= '0;
      o_gen      <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (start) begin
      // New frame or restart: discard the pipe and rewind the raster.
      mode_q     <= mode;
      img_q      <= img_sel;
      fill_q     <= fill_color;
      cx         <= '0;
      cy         <= '0;
      s1_done    <= 1'b0;
      o_valid    <= 1'b0;
      hold_valid <= 1'b0;
    end else if (issue) begin
      if (s1_done) begin
        mode_q <= mode;
        img_q  <= img_sel;
        fill_q <= fill_color;
      end
      cx <= cx + 1'b1;
      if (cx == X_MAX) cy <= cy + 1'b1;
      s1_done    <= last_pix;
      o_valid    <= 1'b1;
      o_x        <= cx;
      o_y        <= cy;
      o_sof      <= (cx == '0) && (cy == '0);
      o_eol      <= (cx == X_MAX);
      o_eof      <= last_pix;
      o_mem      <= (eff_mode == 2'd0);
      o_gen      <= gen_pix;
      hold_valid <= 1'b0;
    end else if (hs) begin
      // Final pixel taken with no continuation: drain the pipe.
      o_valid    <= 1'b0;
      hold_valid <= 1'b0;
      s1_done    <= 1'b0;
    end else if (o_valid && o_mem && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_data  <= mem_rdata;
    end
  end

  assign mem_addr   = {eff_img, cy, cx};
  assign busy       = (state_q == STREAM);
  assign pix_valid  = o_valid;
  assign pix_x      = o_x;
  assign pix_y      = o_y;
  assign sof        = o_valid && o_sof;
  assign eol        = o_valid && o_eol;
  assign eof        = o_valid && o_eof;
  assign frame_done = eof_hs;
  assign pix_data   = !o_valid ? '0 :
                      (o_mem ? (hold_valid ? hold_data : mem_rdata) : o_gen);

endmodule
